// File: rtl/apb_completer_regs.sv
// APB completer with a bank of 32-bit registers, fixed wait states and byte-lane write merging.
// Optional privileged upper half when APB_COMPLETER_PPROT_CHECK_EN is defined.
module apb_completer_regs #(
  parameter int unsigned NUM_REGS    = 16,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] ID_VALUE    = 32'hA9B0_0001
) (
  input  logic                   PCLK,
  input  logic                   PRESET,
  input  logic                   PSEL,
  input  logic [31:0]            PADDR,
  input  logic                   PWRITE,
  input  logic [31:0]            PWDATA,
  input  logic [3:0]             PSTRB,
  input  logic [2:0]             PPROT,
  input  logic                   PENABLE,
  output logic                   PREADY,
  output logic [31:0]            PRDATA,
  output logic                   PSLVERR,
  output logic [NUM_REGS*32-1:0] regs_o,
  output logic                   proto_err_o
);

  localparam int unsigned IdxW      = $clog2(NUM_REGS);
  localparam logic [31:0] SpanBytes = 32'(NUM_REGS * 4);

  typedef enum logic [1:0] {StIdle, StWait, StDone} state_e;

  state_e      state_q;
  logic [3:0]  cnt_q;
  logic [31:0] addr_q;
  logic        write_q;
  logic [31:0] wdata_q;
  logic [3:0]  strb_q;
  logic [2:0]  prot_q;
  logic        pready_q;
  logic [31:0] prdata_q;
  logic        pslverr_q;
  logic        proto_err_q;
  logic [31:0] regs_q [NUM_REGS];

  logic [31:0]     sel_addr;
  logic            sel_write;
  logic [31:0]     offset;
  logic            in_range;
  logic [IdxW-1:0] idx;
  logic            err;
  logic [31:0]     rd_val;
  logic            access;
  logic            ctrl_same;
`ifdef APB_COMPLETER_PPROT_CHECK_EN
  logic [2:0]      sel_prot;
`endif

  // Decode runs on the live bus during setup and on the captured copy afterwards.
  always_comb begin
    sel_addr  = (state_q == StIdle) ? PADDR : addr_q;
    sel_write = (state_q == StIdle) ? PWRITE : write_q;
    offset    = sel_addr - BASE_ADDR;
    in_range  = offset < SpanBytes;
    idx       = offset[IdxW+1:2];
    err       = !in_range || (sel_addr[1:0] != 2'b00) || (sel_write && (idx == '0));
`ifdef APB_COMPLETER_PPROT_CHECK_EN
    sel_prot  = (state_q == StIdle) ? PPROT : prot_q;
    if (in_range && (32'(idx) >= NUM_REGS / 2) && !sel_prot[0]) begin
      err = 1'b1;
    end
`endif
    rd_val = '0;
    if (!err && !sel_write) begin
      rd_val = (idx == '0) ? ID_VALUE : regs_q[idx];
    end
  end

  always_comb begin
    access    = PSEL && PENABLE;
    ctrl_same = (PADDR == addr_q) && (PWRITE == write_q) && (PWDATA == wdata_q) &&
                (PSTRB == strb_q) && (PPROT == prot_q);
  end

  always_ff @(posedge PCLK) begin
    if (PRESET) begin
      state_q     <= StIdle;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      prot_q      <= '0;
      pready_q    <= 1'b0;
      prdata_q    <= '0;
      pslverr_q   <= 1'b0;
      proto_err_q <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      proto_err_q <= 1'b0;
      case (state_q)
        StIdle: begin
          if (PSEL && !PENABLE) begin
            addr_q  <= PADDR;
            write_q <= PWRITE;
            wdata_q <= PWDATA;
            strb_q  <= PSTRB;
            prot_q  <= PPROT;
            if (WAIT_STATES == 0) begin
              state_q   <= StDone;
              pready_q  <= 1'b1;
              prdata_q  <= rd_val;
              pslverr_q <= err;
            end else begin
              cnt_q   <= 4'(WAIT_STATES);
              state_q <= StWait;
            end
          end else if (access) begin
            // ACCESS phase with no setup phase before it
            proto_err_q <= 1'b1;
          end
        end
        StWait: begin
          if (access && ctrl_same) begin
            if (cnt_q == 4'd1) begin
              state_q   <= StDone;
              pready_q  <= 1'b1;
              prdata_q  <= rd_val;
              pslverr_q <= err;
            end else begin
              cnt_q <= cnt_q - 4'd1;
            end
          end else begin
            state_q     <= StIdle;
            proto_err_q <= 1'b1;
          end
        end
        StDone: begin
          state_q   <= StIdle;
          pready_q  <= 1'b0;
          prdata_q  <= '0;
          pslverr_q <= 1'b0;
          if (access && ctrl_same) begin
            if (write_q && !err) begin
              for (int k = 0; k < 4; k++) begin
                if (strb_q[k]) begin
                  regs_q[idx][8*k +: 8] <= wdata_q[8*k +: 8];
                end
              end
            end
          end else begin
            proto_err_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  for (genvar i = 0; i < NUM_REGS; i++) begin : g_regs_o
    if (i == 0) begin : g_id
      assign regs_o[31:0] = ID_VALUE;
    end else begin : g_rw
      assign regs_o[32*i +: 32] = regs_q[i];
    end
  end

  assign PREADY      = pready_q;
  assign PRDATA      = prdata_q;
  assign PSLVERR     = pslverr_q;
  assign proto_err_o = proto_err_q;

endmodule

// File: tb/tb_apb_completer_regs.sv
// Scoreboard bench: two completers (0 and 3 wait states) share the bus, each with its own PSEL.
module tb_apb_completer_regs;

  localparam logic [31:0] Id = 32'hA9B0_0001;

  logic         pclk;
  logic         preset;
  logic         psel0, psel3, penable, pwrite;
  logic [31:0]  paddr, pwdata;
  logic [3:0]   pstrb;
  logic [2:0]   pprot;
  logic         pready0, pslverr0, perr0;
  logic         pready3, pslverr3, perr3;
  logic [31:0]  prdata0, prdata3;
  logic [511:0] regs0, regs3;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          waits;
  } exp_t;

  exp_t q0[$];
  exp_t q3[$];
  int   n_checks = 0;
  int   n_fail   = 0;
  int   lc0      = 0;
  int   lc3      = 0;

  apb_completer_regs #(.NUM_REGS(16), .BASE_ADDR(32'h0), .WAIT_STATES(0), .ID_VALUE(Id)) dut0 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel0), .PADDR(paddr), .PWRITE(pwrite),
    .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .PENABLE(penable), .PREADY(pready0),
    .PRDATA(prdata0), .PSLVERR(pslverr0), .regs_o(regs0), .proto_err_o(perr0)
  );

  apb_completer_regs #(.NUM_REGS(16), .BASE_ADDR(32'h0), .WAIT_STATES(3), .ID_VALUE(Id)) dut3 (
    .PCLK(pclk), .PRESET(preset), .PSEL(psel3), .PADDR(paddr), .PWRITE(pwrite),
    .PWDATA(pwdata), .PSTRB(pstrb), .PPROT(pprot), .PENABLE(penable), .PREADY(pready3),
    .PRDATA(prdata3), .PSLVERR(pslverr3), .regs_o(regs3), .proto_err_o(perr3)
  );

  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitors: pop one expectation per completed transfer, counting PREADY-low ACCESS cycles.
  always @(negedge pclk) begin
    exp_t e;
    if (preset) lc0 = 0;
    else if (psel0 && penable) begin
      if (pready0) begin
        if (q0.size() == 0) check("dut0 unexpected completion", 32'd1, 32'd0);
        else begin
          e = q0.pop_front();
          check("dut0 prdata", prdata0, e.rdata);
          check("dut0 pslverr", 32'(pslverr0), 32'(e.err));
          check("dut0 wait cycles", 32'(lc0), 32'(e.waits));
        end
        lc0 = 0;
      end else lc0++;
    end else lc0 = 0;
  end

  always @(negedge pclk) begin
    exp_t e;
    if (preset) lc3 = 0;
    else if (psel3 && penable) begin
      if (pready3) begin
        if (q3.size() == 0) check("dut3 unexpected completion", 32'd1, 32'd0);
        else begin
          e = q3.pop_front();
          check("dut3 prdata", prdata3, e.rdata);
          check("dut3 pslverr", 32'(pslverr3), 32'(e.err));
          check("dut3 wait cycles", 32'(lc3), 32'(e.waits));
        end
        lc3 = 0;
      end else lc3++;
    end else lc3 = 0;
  end

  // Called just after a rising edge; returns just after the completing edge.
  task automatic xfer(input bit t3, input logic [31:0] addr, input bit wr,
                      input logic [31:0] wd, input logic [3:0] st, input logic [2:0] pr,
                      input logic [31:0] erd, input bit eerr);
    exp_t e;
    int   n;
    e.rdata = erd;
    e.err   = eerr;
    e.waits = t3 ? 3 : 0;
    if (t3) q3.push_back(e);
    else q0.push_back(e);
    paddr   = addr;
    pwrite  = wr;
    pwdata  = wd;
    pstrb   = st;
    pprot   = pr;
    penable = 1'b0;
    if (t3) psel3 = 1'b1;
    else psel0 = 1'b1;
    @(posedge pclk);
    #1 penable = 1'b1;
    n = 0;
    do begin
      @(negedge pclk);
      n++;
    end while (!(t3 ? pready3 : pready0) && n < 40);
    check("pready within bound", 32'(n < 40), 32'd1);
    @(posedge pclk);
    #1;
    psel0   = 1'b0;
    psel3   = 1'b0;
    penable = 1'b0;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    preset = 1'b1;
    psel0 = 1'b0; psel3 = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; pprot = '0;
    repeat (3) @(posedge pclk);
    #1 preset = 1'b0;
    @(negedge pclk);
    check("reset pready", 32'(pready0), 32'd0);
    check("reset prdata", prdata0, 32'h0);
    check("reset pslverr", 32'(pslverr0), 32'd0);
    check("reset proto_err", 32'(perr0), 32'd0);
    check("reset regs_o reg0", regs0[31:0], Id);
    check("reset regs_o reg5", regs0[191:160], 32'h0);
    check("reset dut3 pready", 32'(pready3), 32'd0);
    @(posedge pclk);
    #1;

    // Basic reads, then byte-lane merge on register 2.
    xfer(0, 32'h0, 0, 32'h0, 4'h0, 3'b000, Id, 0);
    xfer(0, 32'h4, 0, 32'h0, 4'h0, 3'b000, 32'h0, 0);
    xfer(0, 32'h8, 1, 32'hDEAD_BEEF, 4'b1111, 3'b000, 32'h0, 0);
    xfer(0, 32'h8, 1, 32'h1122_3344, 4'b0101, 3'b000, 32'h0, 0);
    xfer(0, 32'h8, 0, 32'h0, 4'h0, 3'b000, 32'hDE22_BE44, 0);
    check("regs_o reg2 after merge", regs0[95:64], 32'hDE22_BE44);

    // Error decode: register 0, out of range, misaligned.
    xfer(0, 32'h0, 1, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0, 1);
    xfer(0, 32'h40, 1, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0, 1);
    xfer(0, 32'h6, 1, 32'hFFFF_FFFF, 4'hF, 3'b000, 32'h0, 1);
    xfer(0, 32'h40, 0, 32'h0, 4'h0, 3'b000, 32'h0, 1);
    xfer(0, 32'h6, 0, 32'h0, 4'h0, 3'b000, 32'h0, 1);
    xfer(0, 32'h0, 0, 32'h0, 4'h0, 3'b000, Id, 0);
    xfer(0, 32'h4, 0, 32'h0, 4'h0, 3'b000, 32'h0, 0);
    check("regs_o reg1 after bad writes", regs0[63:32], 32'h0);
    xfer(0, 32'h8, 1, 32'h0, 4'b0000, 3'b000, 32'h0, 0);
    xfer(0, 32'h8, 0, 32'h0, 4'h0, 3'b000, 32'hDE22_BE44, 0);
    xfer(0, 32'h3C, 1, 32'hCAFE_F00D, 4'hF, 3'b001, 32'h0, 0);
    xfer(0, 32'h3C, 0, 32'h0, 4'h0, 3'b001, 32'hCAFE_F00D, 0);
    check("regs_o reg15", regs0[511:480], 32'hCAFE_F00D);

    // Three wait states.
    xfer(1, 32'hC, 0, 32'h0, 4'h0, 3'b000, 32'h0, 0);
    xfer(1, 32'hC, 1, 32'h1234_5678, 4'hF, 3'b000, 32'h0, 0);
    xfer(1, 32'hC, 0, 32'h0, 4'h0, 3'b000, 32'h1234_5678, 0);

    // PSEL dropped during a wait cycle of a write.
    paddr = 32'hC; pwrite = 1'b1; pwdata = 32'hAAAA_AAAA; pstrb = 4'hF; pprot = 3'b000;
    psel3 = 1'b1; penable = 1'b0;
    @(posedge pclk);
    #1 penable = 1'b1;
    @(posedge pclk);
    #1 psel3 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("abort proto_err before", 32'(perr3), 32'd0);
    @(negedge pclk);
    check("abort proto_err pulse", 32'(perr3), 32'd1);
    @(negedge pclk);
    check("abort proto_err cleared", 32'(perr3), 32'd0);
    check("abort reg3 unchanged", regs3[127:96], 32'h1234_5678);
    @(posedge pclk);
    #1;
    xfer(1, 32'hC, 0, 32'h0, 4'h0, 3'b000, 32'h1234_5678, 0);

    // ACCESS without setup.
    paddr = 32'h4; pwrite = 1'b0; psel0 = 1'b1; penable = 1'b1;
    @(posedge pclk);
    #1 psel0 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("idle access proto_err pulse", 32'(perr0), 32'd1);
    @(negedge pclk);
    check("idle access proto_err cleared", 32'(perr0), 32'd0);
    @(posedge pclk);
    #1;

    // Reset while the read of register 0 is in its completing cycle.
    paddr = 32'h0; pwrite = 1'b0; pstrb = 4'h0; psel0 = 1'b1; penable = 1'b0;
    @(posedge pclk);
    #1 penable = 1'b1; preset = 1'b1;
    @(negedge pclk);
    check("pre-reset prdata", prdata0, Id);
    @(posedge pclk);
    #1 preset = 1'b0; psel0 = 1'b0; penable = 1'b0;
    @(negedge pclk);
    check("mid reset pready", 32'(pready0), 32'd0);
    check("mid reset prdata", prdata0, 32'h0);
    check("mid reset pslverr", 32'(pslverr0), 32'd0);
    check("mid reset proto_err", 32'(perr0), 32'd0);
    check("mid reset reg2", regs0[95:64], 32'h0);
    @(posedge pclk);
    #1;
    xfer(0, 32'h8, 0, 32'h0, 4'h0, 3'b000, 32'h0, 0);

`ifdef APB_COMPLETER_PPROT_CHECK_EN
    xfer(0, 32'h20, 1, 32'h55AA_55AA, 4'hF, 3'b000, 32'h0, 1);
    xfer(0, 32'h20, 0, 32'h0, 4'h0, 3'b001, 32'h0, 0);
    xfer(0, 32'h20, 1, 32'h55AA_55AA, 4'hF, 3'b001, 32'h0, 0);
    xfer(0, 32'h20, 0, 32'h0, 4'h0, 3'b001, 32'h55AA_55AA, 0);
    xfer(0, 32'h20, 0, 32'h0, 4'h0, 3'b000, 32'h0, 1);
`else
    xfer(0, 32'h20, 1, 32'h55AA_55AA, 4'hF, 3'b000, 32'h0, 0);
    xfer(0, 32'h20, 0, 32'h0, 4'h0, 3'b000, 32'h55AA_55AA, 0);
`endif
    check("regs_o reg8", regs0[287:256], 32'h55AA_55AA);

    repeat (2) @(posedge pclk);
    check("dut0 expectations drained", 32'(q0.size()), 32'd0);
    check("dut3 expectations drained", 32'(q3.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/apb_completer_regs.md
Name: apb_completer_regs

Overview:
- APB completer (slave) holding a bank of 32-bit registers with a fixed number of wait states and PSTRB byte-lane merging.
- Drives PREADY, PRDATA and PSLVERR back to the initiator. It is the responder for the bus that the team's APB protocol checker monitors.
- Register contents are exported to local logic.
- Flags protocol errors committed by the initiator.

Parameters:
- NUM_REGS, 16: number of 32-bit registers; word-aligned offsets 0x0 to (NUM_REGS-1)*4; legal range 2..64.
- BASE_ADDR, 32'h0000_0000: base address, aligned to NUM_REGS*4.
- WAIT_STATES, 0: cycles PREADY is held low in ACCESS before completion; legal range 0..15.
- ID_VALUE, 32'hA9B0_0001: read-only contents of register 0.

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  synchronous reset, active-high
- PSEL  in  1  completer select
- PADDR  in  32  address
- PWRITE  in  1  1 = write, 0 = read
- PWDATA  in  32  write data
- PSTRB  in  4  write byte strobes
- PPROT  in  3  protection attributes
- PENABLE  in  1  ACCESS phase indicator
- PREADY  out  1  transfer completion
- PRDATA  out  32  read data
- PSLVERR  out  1  transfer error
- regs_o  out  NUM_REGS*32  flattened register contents; reg i at bits [32*i+31:32*i]
- proto_err_o  out  1  one-cycle pulse on an initiator protocol violation

Behaviour:
- Reset (PRESET sampled high at a PCLK edge):
  - state = IDLE; PREADY, PRDATA, PSLVERR and proto_err_o = 0.
  - Registers 1..NUM_REGS-1 = 0.
  - Reset mid-transfer aborts the transfer; no write is committed.
- FSM states: IDLE, WAIT, DONE. All outputs are registered.
- IDLE:
  - PSEL=1 and PENABLE=0 sampled: capture address, PWRITE, PWDATA, PSTRB and PPROT, and decode the error.
  - If WAIT_STATES=0, go to DONE; otherwise load cnt=WAIT_STATES and go to WAIT.
  - PSEL=1 and PENABLE=1 without a preceding setup: pulse proto_err_o and stay in IDLE.
- WAIT:
  - PREADY=0; cnt decrements each cycle.
  - When cnt==1 and PSEL&PENABLE are sampled high, go to DONE.
  - Any completed transfer therefore has exactly WAIT_STATES cycles of PREADY low after the first ACCESS cycle.
- DONE:
  - PREADY=1. PRDATA and PSLVERR are valid only here; at all other times they are 0.
  - At the edge where PSEL&PENABLE&PREADY are sampled, commit any write and return to IDLE.
  - The next setup phase may arrive in the following cycle (back-to-back).
- PSEL or PENABLE dropping in WAIT or DONE, or any change of the captured controls during ACCESS: abort, no write, pulse proto_err_o, return to IDLE.
- Error decode (PSLVERR=1 in DONE):
  - PADDR outside [BASE_ADDR, BASE_ADDR+NUM_REGS*4).
  - PADDR[1:0] != 0.
  - Write to register 0.
  - An erroring write does not modify any register. An erroring read returns PRDATA=0.
- Write merge: byte lane k takes PWDATA[8k+7:8k] when PSTRB[k]=1; otherwise the byte is unchanged. PSTRB=0 is a legal no-op write with PSLVERR=0.
- Read: PRDATA = register content; PSTRB is ignored on reads. Register 0 reads ID_VALUE.
- Latency: at WAIT_STATES=0, 2 cycles from setup to completion; in general 2+WAIT_STATES.
- regs_o updates the cycle after the commit edge.

Optional Feature:
- Macro: APB_COMPLETER_PPROT_CHECK_EN.
- Defined: registers in the upper half (index >= NUM_REGS/2) are privileged. An access with PPROT[0]=0 to one of them gives PSLVERR=1: writes are dropped and reads return 0.
- Undefined: PPROT is captured but ignored, and the upper-half registers behave like any other register.

Test Plan:
- Reset, then read 0x0 and 0x4 with WAIT_STATES=0 -> PRDATA=0xA9B0_0001 then 0x0000_0000; PREADY high on the 2nd cycle of each transfer; PSLVERR=0.
- Write 0xDEAD_BEEF to 0x8 with PSTRB=4'b1111, then write 0x1122_3344 with PSTRB=4'b0101, then read 0x8 -> PRDATA=0xDE22_BE44; regs_o[95:64] matches.
- With WAIT_STATES=3, read 0xC -> PREADY low for exactly 3 ACCESS cycles, high on the 4th; total 5 cycles.
- Write to 0x0, 0x40 (NUM_REGS=16) and 0x6 -> PSLVERR=1 each time; registers unchanged; reads of 0x40 and 0x6 return 0.
- Drop PSEL during a WAIT cycle of a write -> proto_err_o pulses once, register unchanged, next transfer completes normally. Assert PRESET mid-transfer -> all outputs 0 the next cycle.
- With APB_COMPLETER_PPROT_CHECK_EN defined, write 0x20 (index 8) with PPROT=3'b000 -> PSLVERR=1, value unchanged; repeat with PPROT=3'b001 -> write succeeds.
